// File: rtl/atm_auth_responder.sv
// Bank-side authorisation responder for the ATM controller.
// It checks the PIN and the withdrawal amount, counts wrong PINs, locks out the card, and debits the balance on commit.
module atm_auth_responder #(
    parameter int                      PIN_DIGITS = 4,
    parameter logic [4*PIN_DIGITS-1:0] PIN_VALUE  = 16'h1234,
    parameter int                      BAL_W      = 16,
    parameter int unsigned             INIT_BAL   = 500,
    parameter int                      MAX_TRIES  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    card_inserted,
    input  logic                    pin_valid,
    input  logic [4*PIN_DIGITS-1:0] pin_in,
    output logic                    pin_ready,
    input  logic                    amt_valid,
    input  logic [BAL_W-1:0]        amount,
    output logic                    amt_ready,
    input  logic                    commit,
    output logic                    pin_correct,
    output logic                    pin_wrong,
    output logic                    balance_ok,
    output logic                    balance_low,
    output logic                    locked,
    output logic [BAL_W-1:0]        balance
);

    // state    | meaning
    // IDLE     | waiting for a PIN offer while a card is present
    // PIN_CHK  | comparing the latched PIN against the stored one
    // AMT_WAIT | PIN accepted, waiting for a withdrawal amount
    // BAL_CHK  | comparing the latched amount against the balance
    // AUTH     | amount approved, waiting for the dispense commit
    // SESS_END | transaction done, waiting for the card to be removed
    // LOCKED   | too many wrong PINs; only reset leaves this state

    localparam int PIN_W = 4*PIN_DIGITS;
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] MAX_T = TRY_W'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PIN_CHK,
        S_AMT_WAIT,
        S_BAL_CHK,
        S_AUTH,
        S_SESS_END,
        S_LOCKED
    } state_t;

    state_t             state, state_d;
    logic [TRY_W-1:0]   tries, tries_d, tries_inc;
    logic [BAL_W-1:0]   balance_d;
    logic [BAL_W-1:0]   amt_reg;
    logic [PIN_W-1:0]   pin_reg;
    logic               pin_wrong_d, balance_low_d;
    logic               pin_xfer, amt_xfer;

    assign pin_ready = (state == S_IDLE) && card_inserted;
    assign amt_ready = (state == S_AMT_WAIT) && card_inserted;
    assign pin_xfer  = pin_valid && pin_ready;
    assign amt_xfer  = amt_valid && amt_ready;
    assign tries_inc = tries + 1'b1;

    always_comb begin
        state_d       = state;
        tries_d       = tries;
        balance_d     = balance;
        pin_wrong_d   = 1'b0;
        balance_low_d = 1'b0;
        case (state)
            S_IDLE: begin
                if (pin_xfer) state_d = S_PIN_CHK;
            end
            S_PIN_CHK: begin
                if (!card_inserted) begin
                    state_d = S_IDLE;
                end else if (pin_reg == PIN_VALUE) begin
                    tries_d = '0;
                    state_d = S_AMT_WAIT;
                end else if (tries_inc == MAX_T) begin
                    state_d = S_LOCKED;
                end else begin
                    tries_d     = tries_inc;
                    pin_wrong_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_AMT_WAIT: begin
                if (!card_inserted) state_d = S_IDLE;
                else if (amt_xfer)  state_d = S_BAL_CHK;
            end
            S_BAL_CHK: begin
                if (!card_inserted) begin
                    state_d = S_IDLE;
                end else if ((amt_reg != '0) && (amt_reg <= balance)) begin
                    state_d = S_AUTH;
                end else begin
                    balance_low_d = 1'b1;
                    state_d       = S_AMT_WAIT;
                end
            end
            S_AUTH: begin
                // A commit in the same cycle as card removal still dispenses.
                if (commit) begin
                    balance_d = balance - amt_reg;
                    state_d   = S_SESS_END;
                end else if (!card_inserted) begin
                    state_d = S_IDLE;
                end
            end
            S_SESS_END: begin
                if (!card_inserted) state_d = S_IDLE;
            end
            S_LOCKED: begin
                state_d = S_LOCKED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            tries       <= '0;
            balance     <= BAL_W'(INIT_BAL);
            amt_reg     <= '0;
            pin_reg     <= '0;
            pin_correct <= 1'b0;
            pin_wrong   <= 1'b0;
            balance_ok  <= 1'b0;
            balance_low <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state       <= state_d;
            tries       <= tries_d;
            balance     <= balance_d;
            if (pin_xfer) pin_reg <= pin_in;
            if (amt_xfer) amt_reg <= amount;
            pin_correct <= (state_d == S_AMT_WAIT) || (state_d == S_BAL_CHK) ||
                           (state_d == S_AUTH);
            pin_wrong   <= pin_wrong_d;
            balance_ok  <= (state_d == S_AUTH);
            balance_low <= balance_low_d;
            locked      <= (state_d == S_LOCKED);
        end
    end

endmodule

// File: tb/tb_atm_auth_responder.sv
// Directed testbench for atm_auth_responder; it checks expected values that were worked out by hand.
module tb_atm_auth_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        card_inserted;
    logic        pin_valid;
    logic [15:0] pin_in;
    logic        pin_ready;
    logic        amt_valid;
    logic [15:0] amount;
    logic        amt_ready;
    logic        commit;
    logic        pin_correct;
    logic        pin_wrong;
    logic        balance_ok;
    logic        balance_low;
    logic        locked;
    logic [15:0] balance;

    int checks = 0;
    int errors = 0;

    atm_auth_responder dut (
        .clk           (clk),
        .rst           (rst),
        .card_inserted (card_inserted),
        .pin_valid     (pin_valid),
        .pin_in        (pin_in),
        .pin_ready     (pin_ready),
        .amt_valid     (amt_valid),
        .amount        (amount),
        .amt_ready     (amt_ready),
        .commit        (commit),
        .pin_correct   (pin_correct),
        .pin_wrong     (pin_wrong),
        .balance_ok    (balance_ok),
        .balance_low   (balance_low),
        .locked        (locked),
        .balance       (balance)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    // Offers the PIN for one cycle, then lets the check cycle complete.
    task automatic enter_pin(input logic [15:0] p);
        pin_valid = 1'b1;
        pin_in    = p;
        tick();
        pin_valid = 1'b0;
        tick();
    endtask

    task automatic give_amount(input logic [15:0] a);
        amt_valid = 1'b1;
        amount    = a;
        tick();
        amt_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0; card_inserted = 1'b0; pin_valid = 1'b0; pin_in = '0;
        amt_valid = 1'b0; amount = '0; commit = 1'b0;

        // T1 reset
        tick(); tick();
        check("t1_pin_correct", pin_correct, 0);
        check("t1_balance_ok", balance_ok, 0);
        check("t1_locked", locked, 0);
        check("t1_pin_wrong", pin_wrong, 0);
        check("t1_balance_low", balance_low, 0);
        check("t1_balance", balance, 500);
        check("t1_pin_ready", pin_ready, 0);
        rst = 1'b1;

        // T2 happy path
        card_inserted = 1'b1; #1;
        check("t2_pin_ready", pin_ready, 1);
        pin_valid = 1'b1; pin_in = 16'h1234;
        tick();
        pin_valid = 1'b0;
        check("t2_pin_ready_chk", pin_ready, 0);
        check("t2_pin_correct_early", pin_correct, 0);
        tick();
        check("t2_pin_correct", pin_correct, 1);
        check("t2_amt_ready", amt_ready, 1);
        amt_valid = 1'b1; amount = 16'd200;
        tick();
        amt_valid = 1'b0;
        check("t2_balance_ok_early", balance_ok, 0);
        tick();
        check("t2_balance_ok", balance_ok, 1);
        check("t2_pin_correct_auth", pin_correct, 1);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("t2_balance", balance, 300);
        check("t2_balance_ok_end", balance_ok, 0);
        check("t2_pin_correct_end", pin_correct, 0);
        tick();
        check("t2_sess_end_pin_ready", pin_ready, 0);
        card_inserted = 1'b0;
        tick();
        card_inserted = 1'b1; #1;
        check("t2_idle_pin_ready", pin_ready, 1);

        // T3 overdraw, exact balance, zero amount
        do_reset();
        enter_pin(16'h1234);
        give_amount(16'd600);
        check("t3_balance_low", balance_low, 1);
        check("t3_balance_ok", balance_ok, 0);
        check("t3_amt_ready", amt_ready, 1);
        tick();
        check("t3_balance_low_pulse", balance_low, 0);
        give_amount(16'd500);
        check("t3_exact_ok", balance_ok, 1);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("t3_balance_zero", balance, 0);
        card_inserted = 1'b0;
        tick();
        card_inserted = 1'b1;
        enter_pin(16'h1234);
        give_amount(16'd0);
        check("t3_zero_low", balance_low, 1);
        check("t3_zero_ok", balance_ok, 0);
        card_inserted = 1'b0;
        tick();
        check("t3_removal_pin_correct", pin_correct, 0);
        card_inserted = 1'b1;

        // T4 lockout
        do_reset();
        enter_pin(16'h1111);
        check("t4_wrong1", pin_wrong, 1);
        check("t4_locked1", locked, 0);
        tick();
        check("t4_wrong1_pulse", pin_wrong, 0);
        enter_pin(16'h1111);
        check("t4_wrong2", pin_wrong, 1);
        enter_pin(16'h1111);
        check("t4_locked3", locked, 1);
        check("t4_wrong3", pin_wrong, 0);
        check("t4_locked_pin_ready", pin_ready, 0);
        enter_pin(16'h1234);
        check("t4_locked_ignore", pin_correct, 0);
        check("t4_locked_hold", locked, 1);
        card_inserted = 1'b0;
        tick();
        check("t4_locked_card_out", locked, 1);
        card_inserted = 1'b1;
        do_reset();
        check("t4_reset_unlock", locked, 0);

        // T5 abort in AUTH, then commit together with removal
        enter_pin(16'h1234);
        give_amount(16'd200);
        check("t5_auth", balance_ok, 1);
        card_inserted = 1'b0;
        tick();
        check("t5_abort_pin_correct", pin_correct, 0);
        check("t5_abort_balance_ok", balance_ok, 0);
        check("t5_abort_balance", balance, 500);
        card_inserted = 1'b1;
        enter_pin(16'h1234);
        give_amount(16'd200);
        card_inserted = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        check("t5_commit_wins", balance, 300);
        check("t5_commit_balance_ok", balance_ok, 0);
        tick();
        card_inserted = 1'b1; #1;
        check("t5_back_idle", pin_ready, 1);

        // Reset during AUTH discards the pending commit
        enter_pin(16'h1234);
        give_amount(16'd100);
        commit = 1'b1; rst = 1'b0;
        tick();
        commit = 1'b0; rst = 1'b1;
        check("rst_auth_balance", balance, 500);
        check("rst_auth_balance_ok", balance_ok, 0);

        // T6 correct PIN clears tries
        enter_pin(16'h1111);
        enter_pin(16'h1111);
        check("t6_wrong2", pin_wrong, 1);
        enter_pin(16'h1234);
        check("t6_correct", pin_correct, 1);
        card_inserted = 1'b0;
        tick();
        card_inserted = 1'b1;
        enter_pin(16'h1111);
        enter_pin(16'h1111);
        check("t6_wrong_after", pin_wrong, 1);
        check("t6_not_locked", locked, 0);
        enter_pin(16'h1111);
        check("t6_third_locks", locked, 1);

        // Card removed during PIN_CHK discards the check without counting it
        do_reset();
        pin_valid = 1'b1; pin_in = 16'h1111;
        tick();
        pin_valid = 1'b0; card_inserted = 1'b0;
        tick();
        check("discard_no_pulse", pin_wrong, 0);
        card_inserted = 1'b1;
        enter_pin(16'h1111);
        enter_pin(16'h1111);
        check("discard_tries_kept", locked, 0);
        enter_pin(16'h1111);
        check("discard_then_lock", locked, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
